serial_alu: RTL

- Parametrised, digit-serial N-bit ALU.
- Built as the multi-bit successor of the one-bit ALU slice: one DIGIT-wide slice is reused over WIDTH/DIGIT cycles instead of WIDTH slices in a ripple chain.
- Supports the same operation set and opcodes: AND, OR, ADD, SUB, SLT.
- Adds a start/done handshake, registered result, zero/overflow flags and an illegal-opcode flag.
- Sits between the register-file read stage and write-back in the multi-cycle datapath.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_digit_slice.sv | 43 ++++
 rtl/serial_alu.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM state encoding and opcode check shared by the serial ALU
package alu_pkg;

  localparam logic [5:0] OP_AND = 6'd36;
  localparam logic [5:0] OP_OR  = 6'd37;
  localparam logic [5:0] OP_ADD = 6'd32;
  localparam logic [5:0] OP_SUB = 6'd34;
  localparam logic [5:0] OP_SLT = 6'd42;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_digit_slice.sv
// rtl/alu_digit_slice.sv - combinational DIGIT-bit ALU slice (AND/OR/ADD/SUB/SLT)
import alu_pkg::*;

module alu_digit_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  input  logic [5:0]       op,
  output logic [DIGIT-1:0] res,
  output logic             cout,
  output logic             c_msb_in
);

  logic [DIGIT-1:0] bx;
  logic [DIGIT-1:0] sum;
  logic             c;
  logic             cm;
  logic             arith;

  always_comb begin
    arith = (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
    bx    = ((op == OP_SUB) || (op == OP_SLT)) ? ~b : b;
    c     = cin;
    cm    = 1'b0;
    sum   = '0;
    // Ripple across the digit; the carry entering the top bit feeds overflow.
    for (int i = 0; i < DIGIT; i++) begin
      sum[i] = a[i] ^ bx[i] ^ c;
      if (i == DIGIT - 1) cm = c;
      c = (a[i] & bx[i]) | (c & (a[i] ^ bx[i]));
    end
    cout     = arith ? c : 1'b0;
    c_msb_in = arith ? cm : 1'b0;
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      default: res = sum;
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// rtl/serial_alu.sv - digit-serial WIDTH-bit ALU with start/done handshake and flags
import alu_pkg::*;

module serial_alu #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic [WIDTH-1:0] dataOut,
  output logic             carryOut,
  output logic             overflow,
  output logic             zero,
  output logic             error,
  output logic             done
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [5:0]       op_q;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             load, step, finish;

  logic [DIGIT-1:0]       s_res;
  logic                   s_cout, s_cmsb;
  logic [WIDTH+DIGIT-1:0] a_cat;
  logic [WIDTH-1:0]       a_next;
  logic                   ovf, less;
  logic [WIDTH-1:0]       res_final;
  logic                   c_final, v_final;

  alu_digit_slice #(.DIGIT(DIGIT)) u_slice (
    .a        (a_sh[DIGIT-1:0]),
    .b        (b_sh[DIGIT-1:0]),
    .cin      (carry_q),
    .op       (op_q),
    .res      (s_res),
    .cout     (s_cout),
    .c_msb_in (s_cmsb)
  );

  // A doubles as the result shift register: result digits enter at the MSB end.
  assign a_cat  = {s_res, a_sh};
  assign a_next = a_cat[WIDTH+DIGIT-1:DIGIT];

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (cnt == LAST) begin
          finish  = 1'b1;
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          load    = 1'b1;
          state_n = ST_RUN;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    ovf       = s_cmsb ^ s_cout;
    less      = s_res[DIGIT-1] ^ ovf;
    res_final = '0;
    c_final   = 1'b0;
    v_final   = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        res_final = a_next;
        c_final   = s_cout;
        v_final   = ovf;
      end
      OP_SLT: begin
        res_final = WIDTH'(less);
        v_final   = ovf;
      end
      OP_AND, OP_OR: res_final = a_next;
      default: res_final = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      op_q     <= '0;
      carry_q  <= 1'b0;
      cnt      <= '0;
      dataOut  <= '0;
      carryOut <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state <= state_n;
      if (load) begin
        a_sh    <= dataA;
        b_sh    <= dataB;
        op_q    <= Signal;
        cnt     <= '0;
        carry_q <= (Signal == OP_SUB) || (Signal == OP_SLT);
      end else if (step) begin
        a_sh    <= a_next;
        b_sh    <= b_sh >> DIGIT;
        cnt     <= cnt + CW'(1);
        carry_q <= s_cout;
        if (finish) begin
          dataOut  <= res_final;
          carryOut <= c_final;
          overflow <= v_final;
          zero     <= (res_final == '0);
          error    <= !is_legal_op(op_q);
        end
      end
    end
  end

  assign ready = (state == ST_IDLE) || (state == ST_DONE);
  assign done  = (state == ST_DONE);

endmodule
